// File: rtl/push_btn_pkg.sv
// Shared definitions for the push-button bank: instruction field widths,
// opcode values and small helpers to split an instruction word.
package push_btn_pkg;

  localparam int OpWidth   = 4;
  localparam int ImmWidth  = 8;
  localparam int InstWidth = OpWidth + ImmWidth;

  typedef enum logic [OpWidth-1:0] {
    PB_NOP = 4'h0,
    PB_CLR = 4'h1,
    PB_CLA = 4'h2,
    PB_MSK = 4'h3,
    PB_MOD = 4'h4
  } pb_op_e;

  function automatic logic [OpWidth-1:0] pb_opcode(input logic [InstWidth-1:0] inst);
    return inst[InstWidth-1:ImmWidth];
  endfunction

  function automatic logic [ImmWidth-1:0] pb_imm(input logic [InstWidth-1:0] inst);
    return inst[ImmWidth-1:0];
  endfunction

endpackage

// File: rtl/push_btn_bank_if.sv
// Sequencer-side bus of the push-button bank: the oreg instruction stream in,
// the status vector (and its OR) back out to an ireg input.
interface push_btn_bank_if #(
  parameter int Channels = 4
);
  import push_btn_pkg::*;

  logic [InstWidth-1:0] inst;
  logic                 inst_en;
  logic [Channels-1:0]  button_status;
  logic                 any_status;

  modport master (
    output inst,
    output inst_en,
    input  button_status,
    input  any_status
  );

  modport slave (
    input  inst,
    input  inst_en,
    output button_status,
    output any_status
  );

endinterface

// File: rtl/push_btn_debounce.sv
// One button channel: two-flop synchroniser followed by a stability counter.
// The debounced level only changes after the synchronised input has disagreed
// with it for DebounceWait consecutive cycles; press pulses on a rising change.
module push_btn_debounce #(
  parameter int DebounceWait = 10000,
  parameter int DebounceSize = 14
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic deb,
  output logic press
);

  localparam logic [DebounceSize-1:0] CntLast = DebounceSize'(DebounceWait - 1);

  logic                    s1;
  logic                    s2;
  logic [DebounceSize-1:0] cnt;
  logic                    toggle;

  assign toggle = (s2 != deb) && (cnt == CntLast);
  assign press  = toggle & s2;

  // Synchronise the raw level and count how long it has differed from deb.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= button;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (toggle) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/push_btn_bank.sv
// Multi-channel push-button bank. Each channel is debounced independently;
// the top keeps per-channel event latches, an enable mask and a level/event
// mode selector, all programmed through the sequencer instruction bus.
module push_btn_bank
  import push_btn_pkg::*;
#(
  parameter int Channels     = 4,
  parameter int DebounceWait = 10000,
  parameter int DebounceSize = 14
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [Channels-1:0] buttons,
  push_btn_bank_if.slave      bus
);

  logic [Channels-1:0] deb;
  logic [Channels-1:0] press;
  logic [Channels-1:0] latch;
  logic [Channels-1:0] mask;
  logic [Channels-1:0] mode;
  logic [Channels-1:0] latch_next;
  logic [Channels-1:0] mask_next;
  logic [Channels-1:0] mode_next;
  logic [OpWidth-1:0]  opcode;
  logic [ImmWidth-1:0] imm;
  logic [Channels-1:0] imm_ch;
  logic                unused_imm;

  assign opcode     = pb_opcode(bus.inst);
  assign imm        = pb_imm(bus.inst);
  assign imm_ch     = imm[Channels-1:0];
  assign unused_imm = &{1'b0, imm};

  for (genvar i = 0; i < Channels; i++) begin : g_chan
    push_btn_debounce #(
      .DebounceWait(DebounceWait),
      .DebounceSize(DebounceSize)
    ) u_deb (
      .clock (clock),
      .reset (reset),
      .button(buttons[i]),
      .deb   (deb[i]),
      .press (press[i])
    );
  end

  // Decode the instruction, then OR in new presses so a clear never hides one.
  always_comb begin
    latch_next = latch;
    mask_next  = mask;
    mode_next  = mode;
    if (bus.inst_en) begin
      case (opcode)
        PB_CLR:  latch_next = latch & ~imm_ch;
        PB_CLA:  latch_next = '0;
        PB_MSK:  mask_next  = imm_ch;
        PB_MOD:  mode_next  = imm_ch;
        default: ;
      endcase
    end
    latch_next = latch_next | (press & mask);
  end

  // Hold latch, mask and mode state.
  always_ff @(posedge clock) begin
    if (reset) begin
      latch <= '0;
      mask  <= '1;
      mode  <= '0;
    end else begin
      latch <= latch_next;
      mask  <= mask_next;
      mode  <= mode_next;
    end
  end

  assign bus.button_status = (mode & deb & mask) | (~mode & latch);
  assign bus.any_status    = |bus.button_status;

endmodule

// File: tb/tb_push_btn_bank.sv
// Self-checking bench for push_btn_bank with four channels and a short
// debounce window. A behavioural model tracks the expected status from the
// applied inputs; a vector table and hand sequences cover the corner cases.
module tb_push_btn_bank;
  import push_btn_pkg::*;

  localparam int Channels = 4;
  localparam int Wait     = 4;
  localparam int Size     = 3;

  logic                clock = 1'b0;
  logic                reset;
  logic [Channels-1:0] buttons;

  int n_compared   = 0;
  int n_mismatched = 0;

  push_btn_bank_if #(.Channels(Channels)) bus ();

  push_btn_bank #(
    .Channels    (Channels),
    .DebounceWait(Wait),
    .DebounceSize(Size)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .buttons(buttons),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [3:0] raw_hist[$];
  int         run_m[Channels];
  logic [3:0] deb_m;
  logic [3:0] latch_m;
  logic [3:0] mask_m;
  logic [3:0] mode_m;

  typedef struct {
    logic        rst;
    logic [3:0]  btn;
    logic        en;
    logic [11:0] ins;
    logic [3:0]  exp;
  } vec_t;

  vec_t vecs[22];

  task automatic model_edge(input logic rst, input logic [3:0] btn,
                            input logic en, input logic [11:0] ins);
    logic [3:0] seen;
    logic [3:0] pressed;
    logic [3:0] imm;
    logic [3:0] new_latch;
    logic [3:0] new_mask;
    logic [3:0] new_mode;
    if (rst) begin
      raw_hist = '{4'h0, 4'h0};
      for (int c = 0; c < Channels; c++) run_m[c] = 0;
      deb_m   = 4'h0;
      latch_m = 4'h0;
      mask_m  = 4'hF;
      mode_m  = 4'h0;
      return;
    end
    seen = raw_hist.pop_front();
    raw_hist.push_back(btn);
    pressed = 4'h0;
    for (int c = 0; c < Channels; c++) begin
      if (seen[c] != deb_m[c]) begin
        run_m[c] = run_m[c] + 1;
        if (run_m[c] == Wait) begin
          deb_m[c]   = seen[c];
          run_m[c]   = 0;
          pressed[c] = seen[c];
        end
      end else begin
        run_m[c] = 0;
      end
    end
    imm       = ins[3:0];
    new_latch = latch_m;
    new_mask  = mask_m;
    new_mode  = mode_m;
    if (en) begin
      case (ins[11:8])
        4'h1:    new_latch = latch_m & ~imm;
        4'h2:    new_latch = 4'h0;
        4'h3:    new_mask  = imm;
        4'h4:    new_mode  = imm;
        default: ;
      endcase
    end
    latch_m = new_latch | (pressed & mask_m);
    mask_m  = new_mask;
    mode_m  = new_mode;
  endtask

  function automatic logic [3:0] model_status();
    return (mode_m & deb_m & mask_m) | (~mode_m & latch_m);
  endfunction

  task automatic check_value(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_output(input string tag);
    logic [3:0] exp_s;
    exp_s = model_status();
    check_value({tag, "_status"}, 8'(bus.button_status), 8'(exp_s));
    check_value({tag, "_any"}, 8'(bus.any_status), 8'(exp_s != 4'h0));
  endtask

  task automatic apply_stimulus(input logic rst, input logic [3:0] btn,
                                input logic en, input logic [11:0] ins);
    reset       = rst;
    buttons     = btn;
    bus.inst_en = en;
    bus.inst    = ins;
    @(posedge clock);
    model_edge(rst, btn, en, ins);
    @(negedge clock);
    check_output("model");
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 4'h0, 1'b0, 12'h000);
    apply_stimulus(1'b1, 4'h0, 1'b0, 12'h000);
    apply_stimulus(1'b0, 4'h0, 1'b0, 12'h000);
    apply_stimulus(1'b0, 4'h0, 1'b0, 12'h000);
  endtask

  task automatic idle(input int n, input logic [3:0] btn);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, btn, 1'b0, 12'h000);
  endtask

  initial begin
    logic [3:0]  rbtn;
    logic        rrst;
    logic        ren;
    logic [11:0] rins;

    reset       = 1'b1;
    buttons     = 4'h0;
    bus.inst_en = 1'b0;
    bus.inst    = 12'h000;

    // Reset with all buttons high, a ch2 press held 10 cycles, release, CLR
    for (int i = 0; i < 3; i++)   vecs[i] = '{1'b1, 4'hF, 1'b0, 12'h000, 4'h0};
    vecs[3] = '{1'b0, 4'h0, 1'b0, 12'h000, 4'h0};
    for (int i = 4; i < 9; i++)   vecs[i] = '{1'b0, 4'h4, 1'b0, 12'h000, 4'h0};
    for (int i = 9; i < 14; i++)  vecs[i] = '{1'b0, 4'h4, 1'b0, 12'h000, 4'h4};
    for (int i = 14; i < 20; i++) vecs[i] = '{1'b0, 4'h0, 1'b0, 12'h000, 4'h4};
    vecs[20] = '{1'b0, 4'h0, 1'b1, 12'h104, 4'h0};
    vecs[21] = '{1'b0, 4'h0, 1'b0, 12'h000, 4'h0};

    for (int i = 0; i < 22; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].btn, vecs[i].en, vecs[i].ins);
      check_value($sformatf("vec%0d_status", i), 8'(bus.button_status), 8'(vecs[i].exp));
      check_value($sformatf("vec%0d_any", i), 8'(bus.any_status), 8'(vecs[i].exp != 4'h0));
    end

    // Glitch on ch1 shorter than the window
    do_reset();
    idle(3, 4'h2);
    idle(8, 4'h0);
    check_value("glitch_status", 8'(bus.button_status), 8'h00);
    check_value("glitch_cnt", 8'(dut.g_chan[1].u_deb.cnt), 8'h00);

    // Collision: CLR 0x05 on the edge of a ch0 press toggle
    do_reset();
    idle(6, 4'h5);
    check_value("coll_latch", 8'(bus.button_status), 8'h05);
    idle(8, 4'h0);
    idle(5, 4'h1);
    check_value("coll_before", 8'(bus.button_status), 8'h05);
    apply_stimulus(1'b0, 4'h1, 1'b1, 12'h105);
    check_value("collision", 8'(bus.button_status), 8'h01);

    // Masked ch0 press, then level mode on ch3
    do_reset();
    apply_stimulus(1'b0, 4'h0, 1'b1, 12'h30E);
    idle(8, 4'h1);
    check_value("msk_ch0", 8'(bus.button_status), 8'h00);
    apply_stimulus(1'b0, 4'h1, 1'b1, 12'h408);
    idle(5, 4'h9);
    check_value("mod_before", 8'(bus.button_status), 8'h00);
    idle(1, 4'h9);
    check_value("mod_rise", 8'(bus.button_status), 8'h08);
    idle(3, 4'h9);
    idle(5, 4'h1);
    check_value("mod_hold", 8'(bus.button_status), 8'h08);
    idle(1, 4'h1);
    check_value("mod_fall", 8'(bus.button_status), 8'h00);

    // Reset in the middle of a ch0 press window
    do_reset();
    idle(3, 4'h1);
    apply_stimulus(1'b1, 4'h1, 1'b0, 12'h000);
    apply_stimulus(1'b1, 4'h1, 1'b0, 12'h000);
    idle(5, 4'h1);
    check_value("rst_mid_hold", 8'(bus.button_status), 8'h00);
    idle(1, 4'h1);
    check_value("rst_mid_rise", 8'(bus.button_status), 8'h01);

    // Randomised traffic against the model
    do_reset();
    rbtn = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < Channels; c++) begin
        if ($urandom_range(0, 7) == 0) rbtn[c] = ~rbtn[c];
      end
      rrst = ($urandom_range(0, 199) == 0);
      ren  = ($urandom_range(0, 2) == 0);
      rins[7:0]  = 8'($urandom);
      rins[11:8] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 4))
                                               : 4'($urandom_range(0, 15));
      apply_stimulus(rrst, rbtn, ren, rins);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
